// File: rtl/mem_bus_arbiter.sv
// Arbitrates an instruction-fetch and a data-memory requester onto one shared bus,
// with one transaction outstanding, fetch flush/discard and a response timeout.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    input  logic        i_if_flush,
    output logic [31:0] o_if_rdata,
    output logic        o_if_valid,
    output logic        o_if_stall,
    input  logic        i_dm_req,
    input  logic        i_dm_we,
    input  logic [3:0]  i_dm_be,
    input  logic [31:0] i_dm_addr,
    input  logic [31:0] i_dm_wdata,
    output logic [31:0] o_dm_rdata,
    output logic        o_dm_valid,
    output logic        o_mem_stall,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [3:0]  o_bus_be,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_gnt,
    input  logic        i_bus_rvalid,
    input  logic [31:0] i_bus_rdata,
    output logic        o_bus_err
);
    typedef enum logic [2:0] {S_IDLE, S_REQ_IF, S_REQ_DM, S_RSP_IF, S_RSP_DM} state_t;

    localparam logic [7:0] TO = 8'(TIMEOUT_CYC);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_discard, r_we, r_if_valid, r_dm_valid, r_err;
    logic [3:0]  r_be;
    logic [31:0] r_addr, r_wdata, r_if_rdata, r_dm_rdata;

    logic        w_dm_take, w_if_take, w_rsp, w_is_if, w_timeout, w_done, w_drop;
    logic [31:0] w_rsp_data;

    // A requester whose response is being presented this cycle is not re-admitted.
    assign w_dm_take  = i_dm_req & ~r_dm_valid;
    assign w_if_take  = i_if_req & ~i_if_flush & ~r_if_valid;
    assign w_rsp      = (r_state == S_RSP_IF) || (r_state == S_RSP_DM);
    assign w_is_if    = (r_state == S_REQ_IF) || (r_state == S_RSP_IF);
    assign w_timeout  = w_rsp & ~i_bus_rvalid & (r_cnt == TO);
    assign w_done     = w_rsp & (i_bus_rvalid | w_timeout);
    assign w_drop     = r_discard | i_if_flush;
    assign w_rsp_data = i_bus_rvalid ? i_bus_rdata : 32'h0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 8'd0;
            r_discard  <= 1'b0;
            r_we       <= 1'b0;
            r_be       <= 4'h0;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            r_if_rdata <= 32'h0;
            r_dm_rdata <= 32'h0;
            r_if_valid <= 1'b0;
            r_dm_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_if_valid <= 1'b0;
            r_dm_valid <= 1'b0;
            r_err      <= 1'b0;
            if (w_is_if && i_if_flush)
                r_discard <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_dm_take) begin
                        r_state <= S_REQ_DM;
                        r_we    <= i_dm_we;
                        r_be    <= i_dm_be;
                        r_addr  <= i_dm_addr;
                        r_wdata <= i_dm_wdata;
                    end else if (w_if_take) begin
                        r_state <= S_REQ_IF;
                        r_we    <= 1'b0;
                        r_be    <= 4'hF;
                        r_addr  <= i_if_addr;
                    end
                end
                S_REQ_IF: if (i_bus_gnt) begin
                    r_state <= S_RSP_IF;
                    r_cnt   <= 8'd0;
                end
                S_REQ_DM: if (i_bus_gnt) begin
                    r_state <= S_RSP_DM;
                    r_cnt   <= 8'd0;
                end
                S_RSP_IF, S_RSP_DM: begin
                    if (w_done) begin
                        r_state   <= S_IDLE;
                        r_discard <= 1'b0;
                        r_err     <= w_timeout;
                        if (r_state == S_RSP_DM) begin
                            r_dm_valid <= 1'b1;
                            r_dm_rdata <= w_rsp_data;
                        end else if (!w_drop) begin
                            r_if_valid <= 1'b1;
                            r_if_rdata <= w_rsp_data;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_bus_req   = (r_state == S_REQ_IF) || (r_state == S_REQ_DM);
    assign o_bus_we    = r_we;
    assign o_bus_be    = r_be;
    assign o_bus_addr  = r_addr;
    assign o_bus_wdata = r_wdata;
    assign o_bus_err   = r_err;
    assign o_if_rdata  = r_if_rdata;
    assign o_if_valid  = r_if_valid;
    assign o_dm_rdata  = r_dm_rdata;
    assign o_dm_valid  = r_dm_valid;
    assign o_if_stall  = i_if_req & ~r_if_valid;
    assign o_mem_stall = i_dm_req & ~r_dm_valid;
endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 64; maximum response-wait cycles before abort, range 2..255.
REQ-002 Ports:
- i_clk input 1: single clock; all state updates on rising edge.
- i_rst input 1: synchronous, active-high reset.
REQ-003 Fetch requester:
- i_if_req input 1
- i_if_addr input 32
- i_if_flush input 1: IF flush request
- o_if_rdata output 32
- o_if_valid output 1
- o_if_stall output 1
REQ-004 Data requester:
- i_dm_req input 1
- i_dm_we input 1
- i_dm_be input 4
- i_dm_addr input 32
- i_dm_wdata input 32
- o_dm_rdata output 32
- o_dm_valid output 1
- o_mem_stall output 1
REQ-005 Shared bus:
- o_bus_req output 1
- o_bus_we output 1
- o_bus_be output 4
- o_bus_addr output 32
- o_bus_wdata output 32
- i_bus_gnt input 1: command accepted
- i_bus_rvalid input 1: response; also acknowledges writes
- i_bus_rdata input 32
- o_bus_err output 1: timeout pulse

Function
REQ-006 FSM states: IDLE, REQ_IF, REQ_DM, RSP_IF, RSP_DM; at most one bus transaction outstanding.
REQ-007 IDLE, requests: i_dm_req → REQ_DM; else i_if_req & ~i_if_flush → REQ_IF; the command is registered at that edge.
- Simultaneous IF/DM requests: DM wins, because the MEM-stage instruction is older.
REQ-008 IDLE, consumed requests: a requester whose valid is high in the current cycle has its req ignored for that cycle (the response consumes the request).
REQ-009 Bus command drive:
- o_bus_req = 1 exactly in REQ_IF/REQ_DM.
- o_bus_we/be/addr/wdata come from registers and stay stable until i_bus_gnt.
- IF commands drive we=0 and be=4'hF.
REQ-010 Grant: REQ_x with i_bus_gnt=1 → RSP_x next edge; without grant, hold indefinitely (no timeout in REQ states).
REQ-011 Response sampling:
- i_bus_rvalid is honoured only in RSP_IF/RSP_DM; it is ignored in IDLE/REQ states, including the grant cycle.
- RSP_x with rvalid → IDLE.
- o_x_valid = 1 for exactly one cycle after that edge.
- o_x_rdata = captured i_bus_rdata, held until the next capture for that requester.
REQ-012 Latency: with zero-wait bus (gnt in first REQ cycle, rvalid in first RSP cycle), o_x_valid rises 3 cycles after req is sampled in IDLE.
REQ-013 Stall outputs (combinational):
- o_if_stall = i_if_req & ~o_if_valid
- o_mem_stall = i_dm_req & ~o_dm_valid
REQ-014 Flush in REQ_IF or RSP_IF:
- Set a discard flag.
- The transaction still completes on the bus.
- Its response does not assert o_if_valid and does not update o_if_rdata.
- The flag clears on return to IDLE.
REQ-015 Flush in IDLE blocks that cycle's IF request; flush has no effect on DM transactions.
REQ-016 Timeout counter (8-bit):
- Clears on entry to RSP_x; increments each RSP cycle without rvalid.
- On reaching TIMEOUT_CYC → IDLE.
- Next cycle: o_bus_err = 1 for one cycle, o_x_valid = 1 (unless discarded), o_x_rdata = 0.
REQ-017 rvalid arriving in the same cycle the counter reaches TIMEOUT_CYC counts as a normal response; o_bus_err stays 0.

Reset
REQ-018 i_rst sampled high at a rising edge, next cycle:
- FSM in IDLE.
- o_bus_req, o_if_valid, o_dm_valid, o_bus_err all 0.
- o_if_rdata, o_dm_rdata, o_bus_addr, o_bus_wdata all 0; o_bus_be = 0; o_bus_we = 0.
- Discard flag and counter cleared.
REQ-019 Reset mid-transaction:
- Abandons the transaction without any valid or err pulse.
- A late rvalid after reset is ignored (IDLE rule).
REQ-020 Requests are not sampled in a cycle where i_rst = 1.

Verification
REQ-021 IF read, zero-wait bus:
- Stimulus: if_req, addr 0x100; rdata 0x00500093.
- Required: o_bus_req cycle 1, o_if_valid cycle 3 with rdata 0x00500093; o_if_stall high cycles 0-2.
REQ-022 Simultaneous requests:
- Stimulus: if_req + dm_req (write, addr 0x2000, data 0xDEADBEEF, be 4'b0011).
- Required: DM issued first with we=1 and be=0011; IF issued after o_dm_valid.
REQ-023 Grant backpressure:
- Stimulus: gnt held low 5 cycles.
- Required: bus addr/wdata/be/we unchanged across all 5 cycles; RSP entered the cycle after gnt.
REQ-024 Flush:
- Stimulus: i_if_flush during RSP_IF; rvalid with 0x12345678.
- Required: no o_if_valid; o_if_rdata keeps its previous value; IDLE afterwards.
REQ-025 Timeout:
- Stimulus: TIMEOUT_CYC = 4, no rvalid.
- Required: o_bus_err and o_dm_valid pulse together; o_dm_rdata = 0.
- Variant: rvalid exactly at count 4 → normal response, no err.
REQ-026 Reset during RSP_DM:
- Stimulus: reset, then a stray rvalid.
- Required: all outputs zero; no valid pulse; the next request proceeds normally.
